// File: rtl/serial_add_sub.sv
// serial_add_sub: digit-serial adder/subtractor.
//
// Processes DIGIT bits per clock, LSB first, through DIGIT chained full-adder
// cells and a registered carry. An operation takes N = WIDTH/DIGIT RUN cycles;
// done pulses for one cycle when sum/cOut/overflow become valid.
//
// Parameters:
//   WIDTH     operand/result width (>= 2)
//   DIGIT     bits processed per clock (must divide WIDTH)
// Ports:
//   clk       rising-edge clock
//   rstN      asynchronous active-low reset
//   start     request a new operation (accepted in IDLE or DONE)
//   mode      0 = a + b + cIn, 1 = a - b (cIn ignored)
//   a, b      operands, sampled with start
//   cIn       carry-in for add, sampled with start
//   busy      high while an operation is running
//   done      one-cycle pulse when the result becomes valid
//   sum       result, held until the next accepted start
//   cOut      carry-out of the MSB (subtract: 1 = no borrow)
//   overflow  signed overflow (carry into MSB xor carry out of MSB)
module serial_add_sub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cIn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cOut,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $fatal(1, "serial_add_sub: WIDTH must be >= 2 and an exact multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    // Carry chain through the DIGIT full-adder cells of this clock.
    logic [DIGIT:0]   chain;
    logic [DIGIT-1:0] dsum;
    logic [WIDTH-1:0] sum_shift;

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        chain    = '0;
        dsum     = '0;
        chain[0] = carry;
        for (int i = 0; i < DIGIT; i++) begin
            dsum[i]    = a_sh[i] ^ b_sh[i] ^ chain[i];
            chain[i+1] = (a_sh[i] & b_sh[i]) | (chain[i] & (a_sh[i] ^ b_sh[i]));
        end
    end

    // New result digit enters at the MSB end; after N shifts sum is LSB-aligned.
    if (DIGIT == WIDTH) begin : g_single_digit
        assign sum_shift = dsum;
    end else begin : g_multi_digit
        assign sum_shift = {dsum, sum[WIDTH-1:DIGIT]};
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cOut     <= 1'b0;
            overflow <= 1'b0;
            a_sh     <= '0;
            b_sh     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh  <= a;
                        // Subtract is a + ~b + 1.
                        b_sh  <= mode ? ~b : b;
                        carry <= mode ? 1'b1 : cIn;
                        sum   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sum   <= sum_shift;
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    carry <= chain[DIGIT];
                    if (cnt == LAST) begin
                        // On the last digit chain[DIGIT-1] is the carry into bit WIDTH-1.
                        cOut     <= chain[DIGIT];
                        overflow <= chain[DIGIT] ^ chain[DIGIT-1];
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// Testbench for serial_add_sub. Several instances with different WIDTH/DIGIT
// share clock, reset and operand buses; each has its own start. Expected
// results come from an arithmetic reference model and are queued at launch,
// then popped and compared when done is observed.
module tb_serial_add_sub;

    localparam int NDUT = 6;
    localparam int WS [NDUT] = '{8, 8, 16, 8, 16, 32};
    localparam int DS [NDUT] = '{1, 4, 2, 8, 4, 2};

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic            clk = 1'b0;
    logic            rstN;
    logic [NDUT-1:0] start;
    logic            mode;
    logic            cin;
    logic [31:0]     a;
    logic [31:0]     b;
    logic [NDUT-1:0] busy_v;
    logic [NDUT-1:0] done_v;
    logic [NDUT-1:0] cout_v;
    logic [NDUT-1:0] ovf_v;
    logic [31:0]     sum_v [NDUT];

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        logic [WS[g]-1:0] s;
        serial_add_sub #(.WIDTH(WS[g]), .DIGIT(DS[g])) u_dut (
            .clk      (clk),
            .rstN     (rstN),
            .start    (start[g]),
            .mode     (mode),
            .a        (a[WS[g]-1:0]),
            .b        (b[WS[g]-1:0]),
            .cIn      (cin),
            .busy     (busy_v[g]),
            .done     (done_v[g]),
            .sum      (s),
            .cOut     (cout_v[g]),
            .overflow (ovf_v[g])
        );
        assign sum_v[g] = 32'(s);
    end

    // Reference model: plain integer arithmetic on w-bit values.
    function automatic exp_t model(input int w, input logic md, input logic [31:0] aa,
                                   input logic [31:0] bb, input logic ci);
        exp_t r;
        longint unsigned mask, av, bv, res_u;
        longint as_v, bs_v, res_s, smax, smin;
        mask = (64'd1 << w) - 64'd1;
        av   = {32'd0, aa} & mask;
        bv   = {32'd0, bb} & mask;
        as_v = av[w-1] ? (longint'(av) - (64'sd1 <<< w)) : longint'(av);
        bs_v = bv[w-1] ? (longint'(bv) - (64'sd1 <<< w)) : longint'(bv);
        smax = (64'sd1 <<< (w - 1)) - 64'sd1;
        smin = -(64'sd1 <<< (w - 1));
        if (!md) begin
            res_u  = av + bv + (ci ? 64'd1 : 64'd0);
            r.cout = res_u[w];
            res_s  = as_v + bs_v + (ci ? 64'sd1 : 64'sd0);
        end else begin
            res_u  = av - bv;
            r.cout = (av >= bv);
            res_s  = as_v - bs_v;
        end
        r.sum = 32'(res_u & mask);
        r.ovf = (res_s > smax) || (res_s < smin);
        return r;
    endfunction

    // Drive one start pulse (from the preceding negedge) and queue the expectation.
    task automatic launch(input int idx, input logic md, input logic [31:0] aa,
                          input logic [31:0] bb, input logic ci, input string name);
        @(negedge clk);
        a = aa; b = bb; mode = md; cin = ci;
        start[idx] = 1'b1;
        q.push_back(model(WS[idx], md, aa, bb, ci));
        @(posedge clk); #1;
        n_checks++;
        if ({busy_v[idx], done_v[idx]} !== 2'b10)
            $display("FAIL %s start_edge: busy,done got %b expected 10", name, {busy_v[idx], done_v[idx]});
        else n_pass++;
    endtask

    // Wait for done, then check latency, busy duration and the popped result.
    // With disturb set, start/operands/mode/cIn are scrambled every RUN cycle.
    task automatic finish_op(input int idx, input string name, input bit disturb);
        int   edges = 1;
        int   bcnt  = 1;
        bit   timed_out = 1'b0;
        int   n_dig = WS[idx] / DS[idx];
        exp_t e;
        forever begin
            @(negedge clk);
            if (disturb) begin
                start[idx] = 1'($urandom);
                a = $urandom; b = $urandom;
                mode = 1'($urandom); cin = 1'($urandom);
            end else begin
                start[idx] = 1'b0;
            end
            @(posedge clk); #1;
            edges++;
            if (busy_v[idx] === 1'b1) bcnt++;
            if (done_v[idx] === 1'b1) break;
            if (edges > 100) begin
                timed_out = 1'b1;
                break;
            end
        end
        n_checks++;
        if (timed_out) $display("FAIL %s timeout: done not seen within %0d edges", name, edges);
        else n_pass++;
        n_checks++;
        if (edges !== n_dig + 1) $display("FAIL %s latency: got %0d edges expected %0d", name, edges, n_dig + 1);
        else n_pass++;
        n_checks++;
        if (bcnt !== n_dig) $display("FAIL %s busy_cycles: got %0d expected %0d", name, bcnt, n_dig);
        else n_pass++;
        n_checks++;
        if (q.size() == 0) begin
            $display("FAIL %s scoreboard: got empty queue expected one entry", name);
        end else begin
            n_pass++;
            e = q.pop_front();
            n_checks++;
            if (sum_v[idx] !== e.sum) $display("FAIL %s sum: got %h expected %h", name, sum_v[idx], e.sum);
            else n_pass++;
            n_checks++;
            if (cout_v[idx] !== e.cout) $display("FAIL %s cOut: got %b expected %b", name, cout_v[idx], e.cout);
            else n_pass++;
            n_checks++;
            if (ovf_v[idx] !== e.ovf) $display("FAIL %s overflow: got %b expected %b", name, ovf_v[idx], e.ovf);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0; start = '0; a = '0; b = '0; mode = 1'b0; cin = 1'b0;
        #3;
        for (int i = 0; i < NDUT; i++) begin
            n_checks++;
            if ({busy_v[i], done_v[i], cout_v[i], ovf_v[i], sum_v[i]} !== 36'd0)
                $display("FAIL reset_dut%0d: busy,done,cOut,ovf,sum got %b %b %b %b %h expected all 0",
                         i, busy_v[i], done_v[i], cout_v[i], ovf_v[i], sum_v[i]);
            else n_pass++;
        end
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic test_add();
        launch(0, 1'b0, 32'h7F, 32'h01, 1'b0, "add_w8d1");
        finish_op(0, "add_w8d1", 1'b0);
    endtask

    task automatic test_subtract();
        launch(0, 1'b1, 32'h05, 32'h07, 1'b1, "sub_w8d1");
        finish_op(0, "sub_w8d1", 1'b0);
    endtask

    task automatic test_digit4();
        launch(1, 1'b0, 32'hFF, 32'h01, 1'b1, "add_w8d4");
        finish_op(1, "add_w8d4", 1'b0);
        launch(1, 1'b1, 32'h80, 32'h01, 1'b0, "sub_w8d4");
        finish_op(1, "sub_w8d4", 1'b0);
    endtask

    task automatic test_back_to_back();
        launch(2, 1'b0, 32'h1234, 32'h4321, 1'b0, "b2b_first");
        finish_op(2, "b2b_first", 1'b0);
        // start held high through the DONE cycle; launch also checks done dropped.
        launch(2, 1'b0, 32'hFFFF, 32'h0001, 1'b0, "b2b_second");
        finish_op(2, "b2b_second", 1'b1);
        @(negedge clk);
        start[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({busy_v[2], done_v[2], sum_v[2]} !== 34'd0)
                $display("FAIL idle_hold%0d: busy,done,sum got %b %b %h expected 0 0 00000000",
                         i, busy_v[2], done_v[2], sum_v[2]);
            else n_pass++;
        end
        launch(2, 1'b0, 32'h0001, 32'h0002, 1'b0, "restart");
        finish_op(2, "restart", 1'b0);
        @(posedge clk); #1;
        n_checks++;
        if (done_v[2] !== 1'b0) $display("FAIL done_pulse: got %b expected 0", done_v[2]);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        bit saw_done = 1'b0;
        launch(2, 1'b0, 32'h00AB, 32'h0101, 1'b0, "rst_mid");
        @(negedge clk);
        start[2] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rstN = 1'b0;
        #1;
        n_checks++;
        if ({busy_v[2], done_v[2], cout_v[2], ovf_v[2], sum_v[2]} !== 36'd0)
            $display("FAIL rst_mid_async: busy,done,cOut,ovf,sum got %b %b %b %b %h expected all 0",
                     busy_v[2], done_v[2], cout_v[2], ovf_v[2], sum_v[2]);
        else n_pass++;
        q.delete();
        repeat (2) begin
            @(posedge clk); #1;
            if (done_v[2] !== 1'b0) saw_done = 1'b1;
        end
        @(negedge clk);
        rstN = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            if (done_v[2] !== 1'b0) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done) $display("FAIL rst_mid_no_done: got done pulse expected none");
        else n_pass++;
        launch(2, 1'b0, 32'h0003, 32'h0004, 1'b0, "after_rst");
        finish_op(2, "after_rst", 1'b0);
    endtask

    task automatic test_random();
        int ids [4] = '{0, 3, 4, 5};
        foreach (ids[k]) begin
            for (int n = 0; n < 1000; n++) begin
                string nm;
                nm = $sformatf("rand_w%0d_d%0d_op%0d", WS[ids[k]], DS[ids[k]], n);
                launch(ids[k], 1'($urandom), $urandom, $urandom, 1'($urandom), nm);
                finish_op(ids[k], nm, 1'b0);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_subtract();
        test_digit4();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
- Parametrised digit-serial adder/subtractor.
- Processes DIGIT bits per clock, LSB first, through a bank of DIGIT chained full-adder cells and a registered carry.
- Replaces wide combinational ripple adders where area matters more than latency.
- Used by the datapath as a multi-cycle arithmetic unit with a start/done handshake.

Parameters:
- WIDTH, 16, operand and result width in bits; must be ≥ 2.
- DIGIT, 1, bits processed per clock; must divide WIDTH exactly. Illegal values stop elaboration.

Ports:
- clk  input  1  rising-edge clock
- rstN  input  1  asynchronous active-low reset
- start  input  1  request a new operation; sampled only when not busy
- mode  input  1  0 = add (a + b + cIn), 1 = subtract (a − b; cIn ignored)
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- cIn  input  1  carry-in for add; sampled with start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when the result becomes valid
- sum  output  WIDTH  result; holds its value until the next accepted start
- cOut  output  1  carry-out of the MSB. For subtract this is 1 = no borrow.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset is async, active-low, and takes effect immediately, including mid-operation. The operation in flight is abandoned with no done.
  - State goes to IDLE.
  - busy, done, sum, cOut and overflow go to 0.
  - Digit counter and carry register go to 0.
- States: IDLE, RUN, DONE. N = WIDTH/DIGIT.
- Start acceptance (IDLE or DONE, start = 1 at edge k):
  - Latch a into the shift register.
  - Latch b, or ~b when mode = 1, into the shift register.
  - Carry register ← cIn when mode = 0, 1 when mode = 1.
  - Clear sum and the counter; go to RUN.
  - busy = 1 from edge k.
- Each RUN edge:
  - Add the low DIGIT bits of both shift registers plus the carry register.
  - Shift the DIGIT result bits into sum from the MSB side, so sum is LSB-aligned after N edges.
  - Shift operands right by DIGIT; store carry-out; counter++.
- Final RUN edge (k+N):
  - cOut ← final carry-out.
  - overflow ← carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
  - State → DONE; done = 1; busy = 0.
- Latency: result valid and done high during the cycle after edge k+N, i.e. N+1 edges after the start edge.
- DONE lasts exactly one cycle. It goes to IDLE, or back to RUN if start = 1 on that edge (back-to-back). done drops to 0 in either case.
- start while busy is ignored, not queued. Changes on a, b, mode or cIn during RUN have no effect.
- sum, cOut and overflow intermediate values are not guaranteed while busy = 1. Final values hold in IDLE until the next accepted start.
- Subtract: cOut = 0 indicates borrow (unsigned a < b).

Test Plan:
1. WIDTH=8, DIGIT=1; add a=0x7F, b=0x01, cIn=0 → done exactly 9 edges after start edge; sum=0x80, cOut=0, overflow=1; busy high for 8 cycles.
2. WIDTH=8, DIGIT=1; subtract a=0x05, b=0x07, cIn=1 → sum=0xFE, cOut=0 (borrow), overflow=0; cIn ignored.
3. WIDTH=8, DIGIT=4; add a=0xFF, b=0x01, cIn=1 → done 3 edges after start; sum=0x01, cOut=1, overflow=0. Then subtract 0x80−0x01 → sum=0x7F, cOut=1, overflow=1.
4. Back-to-back, then restart after idle (WIDTH=16, DIGIT=2):
   - First op 0x1234+0x4321 → 0x5555; done pulses one cycle.
   - start is held high through the done cycle with 0xFFFF+0x0001 → second result 0x0000, cOut=1.
   - Toggling start, a and b mid-RUN changes nothing.
   - After the second done, start stays low for ≥2 cycles: sum holds 0x0000. Then start 0x0001+0x0002 → sum=0x0003, done pulses.
5. Reset mid-RUN: assert rstN=0 asynchronously between edges 3 and 4 of RUN. All outputs read 0 without waiting for a clock edge, and no done appears. After release, a fresh op 0x0003+0x0004 → 0x0007.
6. Randomised cross-check, 1000 ops per (WIDTH, DIGIT) ∈ {(8,1), (8,8), (16,4), (32,2)} against a reference model: sum, cOut and overflow match; done latency = N+1 every time.
